// File: rtl/cdc_pkg.sv
// cdc_pkg: shared state encoding and gap counter sizing for the pulse pacer
package cdc_pkg;
  typedef enum logic {IDLE = 1'b0, GAP = 1'b1} state_t;
  function automatic int gap_w(input int min_gap);
    return $clog2(min_gap + 1);
  endfunction
endpackage

// File: rtl/pulse_gap_timer.sv
// pulse_gap_timer: down-counter holding off the next pulse for the reload count
module pulse_gap_timer #(
  parameter int MIN_GAP = 6,
  parameter int W = cdc_pkg::gap_w(MIN_GAP)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] reload_i,
  output logic         expire_o,
  output logic         active_o
);
  localparam logic [W-1:0] ONE = 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign expire_o = cnt_q == ONE;
  assign active_o = cnt_q != '0;
  // reload on issue, otherwise count down to zero and rest there
  always_comb cnt_d = load_i ? reload_i : active_o ? cnt_q - ONE : cnt_q;
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/pulse_pacer.sv
// pulse_pacer: queues event strobes and re-emits them as paced single-cycle pulses
module pulse_pacer
  import cdc_pkg::*;
#(
  parameter int MIN_GAP = 6,
  parameter int PEND_W = 4
) (
  input  logic              clk_a,
  input  logic              rst,
  input  logic              evt_in,
  input  logic              clr_ovf,
  output logic              pulse_a,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow,
  output logic              busy
);
  localparam int GW = gap_w(MIN_GAP);
  localparam logic [PEND_W-1:0] ONE = 1;
  localparam logic [PEND_W-1:0] PMAX = '1;
  state_t state_q;
  logic pulse_q, ovf_q, ovf_d, issue, drop, expire, gap_active;
  logic [PEND_W-1:0] pend_q, pend_d;
  assign issue = state_q == IDLE && pend_q != '0;
  assign drop = evt_in && !issue && pend_q == PMAX;
  assign pulse_a = pulse_q;
  assign pend_cnt = pend_q;
  assign overflow = ovf_q;
  assign busy = state_q != IDLE || gap_active || pend_q != '0;
  pulse_gap_timer #(.MIN_GAP(MIN_GAP), .W(GW)) u_gap (
    .clk(clk_a),
    .rst(rst),
    .load_i(issue),
    .reload_i(GW'(MIN_GAP)),
    .expire_o(expire),
    .active_o(gap_active)
  );
  // pending count: an event in an issue cycle nets to zero, so it is never dropped
  always_comb begin
    pend_d = (evt_in && !drop && !issue) ? pend_q + ONE : (!evt_in && issue) ? pend_q - ONE : pend_q;
    ovf_d = drop | (ovf_q & ~clr_ovf);
  end
  // pending counter and sticky overflow, a new drop beats clr_ovf
  always_ff @(posedge clk_a) begin
    pend_q <= rst ? '0 : pend_d;
    ovf_q <= rst ? 1'b0 : ovf_d;
  end
  // pacing FSM: one pulse from IDLE, then hold in GAP until the timer expires
  always_ff @(posedge clk_a) begin
    if (rst) begin
      state_q <= IDLE;
      pulse_q <= 1'b0;
    end else if (state_q == IDLE) begin
      pulse_q <= issue;
      if (issue) state_q <= GAP;
    end else begin
      pulse_q <= 1'b0;
      if (expire) state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_pulse_pacer.sv
// tb_pulse_pacer: directed and random stimulus against a timestamp-based pacing model
module tb_pulse_pacer;
  localparam int MIN_GAP = 6;
  localparam int PEND_W = 3;
  localparam int PMAX = (1 << PEND_W) - 1;
  logic clk_a = 0, rst = 1, evt_in = 0, clr_ovf = 0;
  logic pulse_a, overflow, busy;
  logic [PEND_W-1:0] pend_cnt;
  int tests = 0, fails = 0;
  int cyc = 0, last = 0, pend = 0, ovf = 0, epulse = 0, accepted = 0, dut_pulses = 0;
  bit have_last = 0;
  pulse_pacer #(.MIN_GAP(MIN_GAP), .PEND_W(PEND_W)) dut (
    .clk_a(clk_a),
    .rst(rst),
    .evt_in(evt_in),
    .clr_ovf(clr_ovf),
    .pulse_a(pulse_a),
    .pend_cnt(pend_cnt),
    .overflow(overflow),
    .busy(busy)
  );
  always #5 clk_a = ~clk_a;
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask
  task automatic step(input bit e, input bit c, input bit r);
    bit iss, drp;
    evt_in = e;
    clr_ovf = c;
    rst = r;
    @(posedge clk_a);
    cyc++;
    if (r) begin
      pend = 0; ovf = 0; have_last = 0; epulse = 0; accepted = 0; dut_pulses = 0;
    end else begin
      iss = pend > 0 && (!have_last || cyc - last >= MIN_GAP + 1);
      drp = e && !iss && pend == PMAX;
      if (iss) begin last = cyc; have_last = 1; end
      if (e && !drp) begin pend++; accepted++; end
      if (iss) pend--;
      ovf = drp ? 1 : c ? 0 : ovf;
      epulse = int'(iss);
    end
    #1;
    if (pulse_a === 1'b1) dut_pulses++;
    chk("pulse_a", int'(pulse_a), epulse);
    chk("pend_cnt", int'(pend_cnt), pend);
    chk("overflow", int'(overflow), ovf);
    chk("busy", int'(busy), int'(pend != 0 || (have_last && cyc - last < MIN_GAP)));
  endtask
  initial begin
    int rate;
    repeat (2) step(1, 1, 1);
    repeat (5) step(0, 0, 0);
    step(1, 0, 0);
    repeat (20) step(0, 0, 0);
    repeat (3) step(1, 0, 0);
    repeat (30) step(0, 0, 0);
    repeat (12) step(1, 0, 0);
    chk("ovf_after_burst", int'(overflow), 1);
    repeat (6) step(1, 1, 0);
    chk("ovf_set_beats_clr", int'(overflow), 1);
    step(0, 1, 0);
    chk("ovf_cleared", int'(overflow), 0);
    repeat (100) step(0, 0, 0);
    chk("conserve_a", dut_pulses, accepted);
    repeat (6) step(1, 0, 0);
    step(0, 0, 1);
    repeat (50) step(0, 0, 0);
    chk("no_pulse_after_rst", dut_pulses, 0);
    for (int i = 0; i < 8; i++) begin
      rate = $urandom_range(5, 95);
      repeat (60) step($urandom_range(0, 99) < rate, $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
    end
    repeat (120) step(0, 0, 0);
    chk("conserve_b", dut_pulses, accepted);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
